// File: rtl/tdp_block_ram_if.sv
// Port bundle for the true dual-port RAM: enable, write enable, address, write data
// and registered read data for ports A and B.
interface tdp_block_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  ena;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;

  logic                  enb;
  logic                  web;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] dinb;
  logic [DATA_WIDTH-1:0] doutb;

  modport master (
    output ena, wea, addra, dina,
    output enb, web, addrb, dinb,
    input  douta, doutb
  );

  modport slave (
    input  ena, wea, addra, dina,
    input  enb, web, addrb, dinb,
    output douta, doutb
  );
endinterface

// File: rtl/tdp_block_ram.sv
// True dual-port single-clock RAM; 1-cycle registered reads, write-first per port,
// old data on cross-port read/write collision, port A wins a double write; no backpressure.
module tdp_block_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input logic             clock,
  input logic             resetN,
  tdp_block_ram_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  in_rng_a;
  logic                  in_rng_b;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;
  logic [DATA_WIDTH-1:0] douta_d;
  logic [DATA_WIDTH-1:0] douta_q;
  logic [DATA_WIDTH-1:0] doutb_d;
  logic [DATA_WIDTH-1:0] doutb_q;

  // Reads see the array before this edge's writes, giving old data on collisions.
  always_comb begin
    in_rng_a = ({1'b0, bus.addra} < DEPTH_C);
    in_rng_b = ({1'b0, bus.addrb} < DEPTH_C);
    rd_a     = in_rng_a ? mem[bus.addra] : '0;
    rd_b     = in_rng_b ? mem[bus.addrb] : '0;
  end

  always_comb begin
    douta_d = douta_q;
    if (bus.ena) begin
      douta_d = bus.wea ? bus.dina : rd_a;
    end
  end

  always_comb begin
    doutb_d = doutb_q;
    if (bus.enb) begin
      doutb_d = bus.web ? bus.dinb : rd_b;
    end
  end

  // Array is never cleared; port A is written last so it wins a same-address double write.
  always_ff @(posedge clock) begin
    if (resetN) begin
      if (bus.enb && bus.web && in_rng_b) begin
        mem[bus.addrb] <= bus.dinb;
      end
      if (bus.ena && bus.wea && in_rng_a) begin
        mem[bus.addra] <= bus.dina;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      douta_q <= douta_d;
      doutb_q <= doutb_d;
    end
  end

  assign bus.douta = douta_q;
  assign bus.doutb = doutb_q;

endmodule

// File: tb/tb_tdp_block_ram.sv
// Bench for tdp_block_ram: directed collision/reset/enable cases, a full fill and read-back,
// then random traffic on a small address window, all scored against an array model.
module tb_tdp_block_ram;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic clock;
  logic resetN;

  tdp_block_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  tdp_block_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge: reads use pre-edge contents, writes apply
  // afterwards with port A taking precedence, and a writing port echoes its own data.
  task automatic model_edge(input logic ea, input logic wa, input int aa, input logic [DW-1:0] da,
                            input logic eb, input logic wb, input int ab, input logic [DW-1:0] db);
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    ra = (aa < DEPTH) ? ref_mem[aa] : '0;
    rb = (ab < DEPTH) ? ref_mem[ab] : '0;
    if (ea) exp_a = wa ? da : ra;
    if (eb) exp_b = wb ? db : rb;
    if (eb && wb && ab < DEPTH) ref_mem[ab] = db;
    if (ea && wa && aa < DEPTH) ref_mem[aa] = da;
  endtask

  // Called at a falling edge: drive, clock once, then score both outputs at the next falling edge.
  task automatic op(input string tag,
                    input logic ea, input logic wa, input int aa, input logic [DW-1:0] da,
                    input logic eb, input logic wb, input int ab, input logic [DW-1:0] db);
    bus.ena   = ea;
    bus.wea   = wa;
    bus.addra = AW'(aa);
    bus.dina  = da;
    bus.enb   = eb;
    bus.web   = wb;
    bus.addrb = AW'(ab);
    bus.dinb  = db;
    @(posedge clock);
    model_edge(ea, wa, aa, da, eb, wb, ab, db);
    @(negedge clock);
    check({tag, "_a"}, bus.douta, exp_a);
    check({tag, "_b"}, bus.doutb, exp_b);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_a = '0;
    exp_b = '0;
    resetN    = 1'b0;
    bus.ena   = 1'b0;
    bus.wea   = 1'b0;
    bus.addra = '0;
    bus.dina  = '0;
    bus.enb   = 1'b0;
    bus.web   = 1'b0;
    bus.addrb = '0;
    bus.dinb  = '0;

    repeat (2) @(negedge clock);
    check("reset_a", bus.douta, '0);
    check("reset_b", bus.doutb, '0);
    resetN = 1'b1;

    // Reset clears outputs without a clock, blocks writes, and keeps the array.
    op("pre_w",  1, 1, 20, 32'hCAFEF00D, 0, 0, 0, '0);
    op("dead",   1, 1, 21, 32'hDEADBEEF, 1, 1, 22, 32'hDEADBEEF);
    #2 resetN = 1'b0;
    #1;
    check("async_clr_a", bus.douta, '0);
    check("async_clr_b", bus.doutb, '0);
    exp_a = '0;
    exp_b = '0;
    @(negedge clock);
    bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = AW'(20); bus.dina = 32'h0BAD0BAD;
    bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = AW'(21); bus.dinb = 32'h0BAD0BAD;
    @(posedge clock);
    @(negedge clock);
    check("rst_hold_a", bus.douta, '0);
    check("rst_hold_b", bus.doutb, '0);
    resetN = 1'b1;
    op("post_rst", 1, 0, 21, '0, 1, 0, 20, '0);

    // Write on A, read on B the following edge.
    op("wr5",   1, 1, 5, 32'h12345678, 0, 0, 0, '0);
    op("rd5",   0, 0, 0, '0, 1, 0, 5, '0);

    // A writes while B reads the same word: B sees the old word, then the new one.
    op("wr7",   1, 1, 7, 32'h00000011, 0, 0, 0, '0);
    op("col7",  1, 1, 7, 32'hAAAA0000, 1, 0, 7, '0);
    op("rd7",   0, 0, 0, '0, 1, 0, 7, '0);

    // Mirror case: B writes while A reads.
    op("col8",  1, 0, 8, '0, 1, 1, 8, 32'h5A5A5A5A);
    op("rd8",   1, 0, 8, '0, 0, 0, 0, '0);

    // Double write: A's word is kept.
    op("dw9",   1, 1, 9, 32'h00000001, 1, 1, 9, 32'h00000002);
    op("rd9",   1, 0, 9, '0, 1, 0, 9, '0);

    // Disabled ports neither write nor change their output.
    op("wr3",   1, 1, 3, 32'h00000033, 0, 0, 0, '0);
    op("dis3",  0, 1, 3, 32'h000000FF, 0, 1, 3, 32'h000000EE);
    op("rd3",   0, 0, 0, '0, 1, 0, 3, '0);

    for (int i = 0; i < DEPTH; i++) op("fill", 1, 1, i, DW'(i), 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) op("rdbk", 0, 0, 0, '0, 1, 0, i, '0);
    op("last", 1, 0, DEPTH - 1, '0, 1, 0, DEPTH - 1, '0);

    // Random traffic confined to 16 words so collisions are frequent.
    for (int n = 0; n < 2000; n++) begin
      op("rand",
         1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
         1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
